// File: rtl/instr_decode_stage.sv
// Instruction decode stage: splits an instruction word into fields, classifies it,
// and holds results in an output register backed by a one-entry skid register.
module instr_decode_stage #(
    parameter int REG_W   = 5,
    parameter int LIT_W   = 16,
    parameter int XLEN    = 32,
    parameter int EXT_OPS = 1,
    parameter int CNT_W   = 16,
    localparam int INSTR_W = 6 + 2 * REG_W + LIT_W
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               flush,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [INSTR_W-1:0] in_instr,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [5:0]         out_opcode,
    output logic [REG_W-1:0]   out_rc,
    output logic [REG_W-1:0]   out_ra,
    output logic [REG_W-1:0]   out_rb,
    output logic [XLEN-1:0]    out_lit,
    output logic [2:0]         out_class,
    output logic               out_we,
    output logic               out_illegal,
    output logic [CNT_W-1:0]   decode_count,
    output logic [CNT_W-1:0]   illegal_count
);

    localparam int DEC_W = 6 + 3 * REG_W + XLEN + 5;

    // Packed decode result: {opcode, rc, ra, rb, lit, class, we, illegal}
    function automatic logic [DEC_W-1:0] decode_word(input logic [INSTR_W-1:0] w);
        logic [5:0]       op;
        logic [REG_W-1:0] rc;
        logic [REG_W-1:0] ra;
        logic [REG_W-1:0] rb;
        logic [LIT_W-1:0] lit;
        logic [XLEN-1:0]  lit_x;
        logic [2:0]       cls;
        logic             we;
        logic             ill;
        op    = w[INSTR_W-1 -: 6];
        rc    = w[INSTR_W-7 -: REG_W];
        ra    = w[INSTR_W-7-REG_W -: REG_W];
        lit   = w[LIT_W-1:0];
        rb    = lit[LIT_W-1 -: REG_W];
        lit_x = XLEN'($signed(lit));
        cls   = 3'd7;
        we    = 1'b0;
        case (op[5:4])
            2'b10: begin
                if (op[2:0] != 3'b111) begin
                    cls = 3'd0;
                    we  = 1'b1;
                end else begin
                    cls = 3'd7;
                end
            end
            2'b11: begin
                if (op[2:0] != 3'b111) begin
                    cls = 3'd1;
                    we  = 1'b1;
                end else begin
                    cls = 3'd7;
                end
            end
            2'b01: begin
                if (op[3]) begin
                    case (op[2:0])
                        3'b000: begin cls = 3'd2; we = 1'b1; end
                        3'b001: begin cls = 3'd2; we = 1'b0; end
                        3'b011, 3'b100, 3'b101: begin cls = 3'd3; we = 1'b1; end
                        3'b010, 3'b110: begin
                            cls = (EXT_OPS != 0) ? 3'd4 : 3'd7;
                            we  = 1'b0;
                        end
                        3'b111: begin
                            cls = (EXT_OPS != 0) ? 3'd2 : 3'd7;
                            we  = (EXT_OPS != 0);
                        end
                        default: begin cls = 3'd7; we = 1'b0; end
                    endcase
                end else begin
                    cls = 3'd7;
                end
            end
            default: cls = 3'd7;
        endcase
        ill = (cls == 3'd7);
        // The all-ones register reads as zero, so writes to it are suppressed
        if (rc == {REG_W{1'b1}}) begin
            we = 1'b0;
        end else begin
            we = we & ~ill;
        end
        return {op, rc, ra, rb, lit_x, cls, we, ill};
    endfunction

    logic [DEC_W-1:0] dec_s;
    logic [DEC_W-1:0] out_r;
    logic [DEC_W-1:0] skid_r;
    logic             out_valid_r;
    logic             skid_valid_r;
    logic             in_ready_r;
    logic [CNT_W-1:0] decode_count_r;
    logic [CNT_W-1:0] illegal_count_r;
    logic             in_fire_s;
    logic             out_fire_s;

    assign dec_s      = decode_word(in_instr);
    assign in_fire_s  = in_valid & in_ready_r;
    assign out_fire_s = out_valid_r & out_ready;

    // Output/skid register control; skid only fills while the output is stalled
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_r        <= {DEC_W{1'b0}};
            skid_r       <= {DEC_W{1'b0}};
            out_valid_r  <= 1'b0;
            skid_valid_r <= 1'b0;
            in_ready_r   <= 1'b1;
        end else if (flush) begin
            out_valid_r  <= 1'b0;
            skid_valid_r <= 1'b0;
            in_ready_r   <= 1'b1;
        end else if (out_fire_s || !out_valid_r) begin
            if (skid_valid_r) begin
                out_r        <= skid_r;
                out_valid_r  <= 1'b1;
                skid_valid_r <= 1'b0;
                in_ready_r   <= 1'b1;
            end else if (in_fire_s) begin
                out_r       <= dec_s;
                out_valid_r <= 1'b1;
            end else begin
                out_valid_r <= 1'b0;
            end
        end else if (in_fire_s) begin
            skid_r       <= dec_s;
            skid_valid_r <= 1'b1;
            in_ready_r   <= 1'b0;
        end
    end

    // Saturating statistics counters; flush does not touch them
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            decode_count_r  <= {CNT_W{1'b0}};
            illegal_count_r <= {CNT_W{1'b0}};
        end else if (out_fire_s) begin
            if (decode_count_r != {CNT_W{1'b1}}) begin
                decode_count_r <= decode_count_r + CNT_W'(1);
            end
            if (out_r[0] && (illegal_count_r != {CNT_W{1'b1}})) begin
                illegal_count_r <= illegal_count_r + CNT_W'(1);
            end
        end
    end

    assign in_ready      = in_ready_r;
    assign out_valid     = out_valid_r;
    assign decode_count  = decode_count_r;
    assign illegal_count = illegal_count_r;
    assign {out_opcode, out_rc, out_ra, out_rb, out_lit, out_class, out_we, out_illegal} = out_r;

endmodule

// File: tb/tb_instr_decode_stage.sv
// Self-checking bench for instr_decode_stage: directed scenarios plus randomized
// traffic scored against a queue-based reference model.
module tb_instr_decode_stage;

    typedef struct packed {
        logic [5:0]  op;
        logic [4:0]  rc;
        logic [4:0]  ra;
        logic [4:0]  rb;
        logic [31:0] lit;
        logic [2:0]  cls;
        logic        we;
        logic        ill;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b0;
    logic [31:0] in_instr = 32'd0;
    logic        in_ready, out_valid, out_we, out_illegal;
    logic [5:0]  out_opcode;
    logic [4:0]  out_rc, out_ra, out_rb;
    logic [31:0] out_lit;
    logic [2:0]  out_class;
    logic [15:0] decode_count, illegal_count;

    logic        in_valid2 = 1'b0;
    logic [31:0] in_instr2 = 32'd0;
    logic        out_ready2 = 1'b1;
    logic        flush2 = 1'b0;
    logic        in_ready2, out_valid2, out_we2, out_illegal2;
    logic [5:0]  out_opcode2;
    logic [4:0]  out_rc2, out_ra2, out_rb2;
    logic [31:0] out_lit2;
    logic [2:0]  out_class2;
    logic [1:0]  decode_count2, illegal_count2;

    int   n_cmp = 0;
    int   n_fail = 0;
    exp_t q[$];
    int   exp_dec = 0;
    int   exp_ill = 0;

    instr_decode_stage dut (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
        .in_instr(in_instr), .out_valid(out_valid), .out_ready(out_ready),
        .out_opcode(out_opcode), .out_rc(out_rc), .out_ra(out_ra), .out_rb(out_rb),
        .out_lit(out_lit), .out_class(out_class), .out_we(out_we), .out_illegal(out_illegal),
        .decode_count(decode_count), .illegal_count(illegal_count)
    );

    instr_decode_stage #(.EXT_OPS(0), .CNT_W(2)) dut2 (
        .clk(clk), .rst(rst), .flush(flush2), .in_valid(in_valid2), .in_ready(in_ready2),
        .in_instr(in_instr2), .out_valid(out_valid2), .out_ready(out_ready2),
        .out_opcode(out_opcode2), .out_rc(out_rc2), .out_ra(out_ra2), .out_rb(out_rb2),
        .out_lit(out_lit2), .out_class(out_class2), .out_we(out_we2), .out_illegal(out_illegal2),
        .decode_count(decode_count2), .illegal_count(illegal_count2)
    );

    always #5 clk = ~clk;

    // Reference decode built from the opcode map as plain integer ranges
    function automatic exp_t ref_decode(input logic [31:0] w, input bit ext);
        exp_t e;
        int   op;
        op    = int'(w[31:26]);
        e.op  = w[31:26];
        e.rc  = w[25:21];
        e.ra  = w[20:16];
        e.rb  = w[15:11];
        e.lit = {{16{w[15]}}, w[15:0]};
        if (op < 24 || (op >= 32 && op % 8 == 7) || (!ext && (op == 26 || op == 30 || op == 31)))
            e.cls = 3'd7;
        else if (op >= 48) e.cls = 3'd1;
        else if (op >= 32) e.cls = 3'd0;
        else if (op == 24 || op == 25 || op == 31) e.cls = 3'd2;
        else if (op >= 27 && op <= 29) e.cls = 3'd3;
        else e.cls = 3'd4;
        e.ill = (e.cls == 3'd7);
        e.we  = !e.ill && (e.cls == 3'd0 || e.cls == 3'd1 || e.cls == 3'd3 || op == 24 || op == 31)
                && (e.rc != 5'd31);
        return e;
    endfunction

    // Scoreboard: checks occupancy, fields and counters, then advances the model
    always @(negedge clk) begin
        if (rst) begin
            q.delete();
            exp_dec = 0;
            exp_ill = 0;
        end else begin
            n_cmp++;
            if (out_valid !== (q.size() > 0)) begin
                n_fail++; $display("FAIL sb_out_valid: got %b want %b", out_valid, q.size() > 0);
            end
            n_cmp++;
            if (in_ready !== (q.size() < 2)) begin
                n_fail++; $display("FAIL sb_in_ready: got %b want %b", in_ready, q.size() < 2);
            end
            n_cmp++;
            if (decode_count !== 16'(exp_dec) || illegal_count !== 16'(exp_ill)) begin
                n_fail++; $display("FAIL sb_counts: got %0d/%0d want %0d/%0d",
                                   decode_count, illegal_count, exp_dec, exp_ill);
            end
            if (out_valid && q.size() > 0) begin
                n_cmp++;
                if ({out_opcode, out_rc, out_ra, out_rb, out_lit, out_class, out_we, out_illegal} !== q[0]) begin
                    n_fail++; $display("FAIL sb_fields: got %h want %h",
                        {out_opcode, out_rc, out_ra, out_rb, out_lit, out_class, out_we, out_illegal}, q[0]);
                end
            end
            if (out_valid && out_ready && q.size() > 0) begin
                if (q[0].ill) exp_ill++;
                exp_dec++;
                void'(q.pop_front());
            end
            if (flush) q.delete();
            else if (in_valid && in_ready) q.push_back(ref_decode(in_instr, 1'b1));
        end
    end

    task automatic drive(input logic iv, input logic [31:0] w, input logic ordy, input logic fl);
        in_valid = iv; in_instr = w; out_ready = ordy; flush = fl;
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clk);
        #1;
        n_cmp++;
        if ({out_valid, in_ready, decode_count, illegal_count, out_opcode, out_lit, out_class, out_we} !== {1'b1 ^ 1'b1, 1'b1, 16'd0, 16'd0, 6'd0, 32'd0, 3'd0, 1'b0}) begin
            n_fail++; $display("FAIL reset_state: got v=%b r=%b dc=%0d ic=%0d op=%h", out_valid, in_ready, decode_count, illegal_count, out_opcode);
        end
        rst = 1'b0;
    endtask

    task automatic test_illegal();
        drive(1'b1, 32'h0000_0000, 1'b1, 1'b0);
        n_cmp++;
        if ({out_valid, out_class, out_illegal, out_we} !== {1'b1, 3'd7, 1'b1, 1'b0}) begin
            n_fail++; $display("FAIL illegal_zero: got v=%b cls=%0d ill=%b", out_valid, out_class, out_illegal);
        end
        drive(1'b1, 32'h9C00_0000, 1'b1, 1'b0);
        n_cmp++;
        if ({out_opcode, out_class, out_illegal} !== {6'b100111, 3'd7, 1'b1}) begin
            n_fail++; $display("FAIL illegal_100111: got op=%b cls=%0d ill=%b", out_opcode, out_class, out_illegal);
        end
        drive(1'b0, 32'd0, 1'b1, 1'b0);
        n_cmp++;
        if ({out_valid, decode_count, illegal_count} !== {1'b0, 16'd2, 16'd2}) begin
            n_fail++; $display("FAIL illegal_counts: got dc=%0d ic=%0d want 2/2", decode_count, illegal_count);
        end
    endtask

    task automatic test_addc();
        drive(1'b1, 32'hC022_FFFC, 1'b1, 1'b0);
        n_cmp++;
        if ({out_valid, out_opcode, out_rc, out_ra, out_lit, out_class, out_we, out_illegal} !==
            {1'b1, 6'b110000, 5'd1, 5'd2, 32'hFFFF_FFFC, 3'd1, 1'b1, 1'b0}) begin
            n_fail++; $display("FAIL addc: got op=%b rc=%0d ra=%0d lit=%h cls=%0d we=%b",
                               out_opcode, out_rc, out_ra, out_lit, out_class, out_we);
        end
        drive(1'b0, 32'd0, 1'b1, 1'b0);
    endtask

    task automatic test_add();
        drive(1'b1, 32'h8061_1000, 1'b1, 1'b0);
        n_cmp++;
        if ({out_class, out_rc, out_ra, out_rb, out_we} !== {3'd0, 5'd3, 5'd1, 5'd2, 1'b1}) begin
            n_fail++; $display("FAIL add_r3: got cls=%0d rc=%0d ra=%0d rb=%0d we=%b", out_class, out_rc, out_ra, out_rb, out_we);
        end
        drive(1'b1, 32'h83E1_1000, 1'b1, 1'b0);
        n_cmp++;
        if ({out_class, out_rc, out_we} !== {3'd0, 5'd31, 1'b0}) begin
            n_fail++; $display("FAIL add_r31: got cls=%0d rc=%0d we=%b want we=0", out_class, out_rc, out_we);
        end
        drive(1'b0, 32'd0, 1'b1, 1'b0);
    endtask

    task automatic test_back_to_back();
        logic [4:0] exp_rc [6];
        logic       exp_rdy [6];
        logic       iv [6];
        logic       ordy [6];
        logic [31:0] w [6];
        exp_rc  = '{5'd3, 5'd3, 5'd3, 5'd5, 5'd7, 5'd7};
        exp_rdy = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
        iv      = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        ordy    = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
        w       = '{32'h8061_1000, 32'h80A1_1000, 32'h80E1_1000, 32'h80E1_1000, 32'h80E1_1000, 32'd0};
        for (int i = 0; i < 6; i++) begin
            drive(iv[i], w[i], ordy[i], 1'b0);
            if (i < 5) begin
                n_cmp++;
                if ({out_valid, out_rc, in_ready} !== {1'b1, exp_rc[i], exp_rdy[i]}) begin
                    n_fail++; $display("FAIL b2b_step%0d: got v=%b rc=%0d rdy=%b want rc=%0d rdy=%b",
                                       i, out_valid, out_rc, in_ready, exp_rc[i], exp_rdy[i]);
                end
            end
        end
        n_cmp++;
        if ({out_valid, decode_count} !== {1'b0, 16'd8}) begin
            n_fail++; $display("FAIL b2b_drain: got v=%b dc=%0d want 0/8", out_valid, decode_count);
        end
    endtask

    task automatic test_flush();
        drive(1'b1, 32'h8061_1000, 1'b0, 1'b0);
        drive(1'b1, 32'h80A1_1000, 1'b0, 1'b0);
        drive(1'b1, 32'h80E1_1000, 1'b0, 1'b1);
        n_cmp++;
        if ({out_valid, in_ready, decode_count, illegal_count} !== {1'b0, 1'b1, 16'd8, 16'd2}) begin
            n_fail++; $display("FAIL flush: got v=%b rdy=%b dc=%0d ic=%0d want 0/1/8/2", out_valid, in_ready, decode_count, illegal_count);
        end
        drive(1'b0, 32'd0, 1'b1, 1'b0);
        n_cmp++;
        if (out_valid !== 1'b0) begin
            n_fail++; $display("FAIL flush_discard: got v=%b want 0", out_valid);
        end
    endtask

    task automatic test_rst_mid();
        drive(1'b1, 32'h8061_1000, 1'b0, 1'b0);
        drive(1'b1, 32'h80A1_1000, 1'b0, 1'b0);
        rst = 1'b1;
        #1;
        n_cmp++;
        if ({out_valid, in_ready, decode_count, out_opcode, out_lit} !== {1'b0, 1'b1, 16'd0, 6'd0, 32'd0}) begin
            n_fail++; $display("FAIL rst_async: got v=%b rdy=%b dc=%0d op=%h", out_valid, in_ready, decode_count, out_opcode);
        end
        in_valid = 1'b1; in_instr = 32'h80E1_1000;
        @(posedge clk); #1;
        n_cmp++;
        if (out_valid !== 1'b0) begin
            n_fail++; $display("FAIL rst_hold: got v=%b want 0", out_valid);
        end
        rst = 1'b0;
        @(posedge clk); #1;
        n_cmp++;
        if ({out_valid, out_rc} !== {1'b1, 5'd7}) begin
            n_fail++; $display("FAIL rst_first_accept: got v=%b rc=%0d want 1/7", out_valid, out_rc);
        end
        drive(1'b0, 32'd0, 1'b1, 1'b0);
    endtask

    task automatic test_random();
        logic [31:0] w;
        for (int i = 0; i < 800; i++) begin
            w = $urandom;
            if ($urandom_range(0, 7) == 0) w[25:21] = 5'd31;
            drive($urandom_range(0, 9) < 7, w, $urandom_range(0, 9) < 6, $urandom_range(0, 49) == 0);
        end
        repeat (3) drive(1'b0, 32'd0, 1'b1, 1'b0);
        n_cmp++;
        if ({out_valid, decode_count} !== {1'b0, 16'(exp_dec)}) begin
            n_fail++; $display("FAIL random_drain: got v=%b dc=%0d want 0/%0d", out_valid, decode_count, exp_dec);
        end
    endtask

    task automatic test_ext0();
        logic [31:0] w [6];
        logic [2:0]  cls [6];
        logic        we [6];
        w   = '{32'h6800_0000, 32'h7800_0000, 32'h7C00_0000, 32'h6000_0000, 32'h6400_0000, 32'h6800_0000};
        cls = '{3'd7, 3'd7, 3'd7, 3'd2, 3'd2, 3'd7};
        we  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        for (int i = 0; i < 6; i++) begin
            in_valid2 = 1'b1; in_instr2 = w[i];
            @(posedge clk); #1;
            n_cmp++;
            if ({out_valid2, out_class2, out_we2, out_illegal2} !== {1'b1, cls[i], we[i], cls[i] == 3'd7}) begin
                n_fail++; $display("FAIL ext0_word%0d: got cls=%0d we=%b ill=%b want cls=%0d", i, out_class2, out_we2, out_illegal2, cls[i]);
            end
        end
        in_valid2 = 1'b0;
        @(posedge clk); #1;
        n_cmp++;
        if ({decode_count2, illegal_count2} !== {2'd3, 2'd3}) begin
            n_fail++; $display("FAIL ext0_saturate: got dc=%0d ic=%0d want 3/3", decode_count2, illegal_count2);
        end
    endtask

    initial begin
        test_reset();
        test_illegal();
        test_addc();
        test_add();
        test_back_to_back();
        test_flush();
        test_rst_mid();
        test_random();
        test_ext0();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
